// File: rtl/mips_sdram_bridge_pkg.sv
// mips_sdram_bridge_pkg: shared FSM states, defaults and half-select helpers for the MIPS-to-SDRAM bridge
package mips_sdram_bridge_pkg;
  typedef enum logic [2:0] {IDLE, LO_REQ, HI_GAP, HI_REQ, DONE} state_t;
  localparam int TIMEOUT_CYC_DEF = 1023;
  localparam int ADDR_W_DEF = 22;
  function automatic logic [15:0] pick_half(input logic [31:0] w, input logic hi);
    return hi ? w[31:16] : w[15:0];
  endfunction
  function automatic logic [1:0] pick_be(input logic [3:0] be, input logic hi);
    return hi ? be[3:2] : be[1:0];
  endfunction
endpackage

// File: rtl/mips_sdram_bridge_if.sv
// mips_sdram_bridge_if: CPU-side load/store bus and SDRAM host-port bus
interface mips_sdram_bridge_cpu_if;
  logic [31:0] addr, wdata, rdata;
  logic [3:0] be;
  logic rd, wr, stall, ack, err;
  modport master (output addr, wdata, be, rd, wr, input rdata, stall, ack, err);
  modport slave (input addr, wdata, be, rd, wr, output rdata, stall, ack, err);
endinterface

interface mips_sdram_bridge_mem_if import mips_sdram_bridge_pkg::*; #(parameter int ADDR_W = ADDR_W_DEF);
  logic [ADDR_W-1:0] addr;
  logic [15:0] data, rdata;
  logic [1:0] dm;
  logic rd, wr, valid, done;
  modport master (output addr, data, dm, rd, wr, input rdata, valid, done);
  modport slave (input addr, data, dm, rd, wr, output rdata, valid, done);
endinterface

// File: rtl/mips_sdram_bridge_watchdog.sv
// mips_sdram_bridge_watchdog: per-access cycle counter; expire fires in the TIMEOUT_CYC-th enabled cycle
module mips_sdram_bridge_watchdog import mips_sdram_bridge_pkg::*; #(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [15:0] cnt;
  assign expire = en && cnt == 16'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : en ? cnt + 16'd1 : cnt;
endmodule

// File: rtl/mips_sdram_bridge.sv
// mips_sdram_bridge: splits a 32-bit MIPS load/store into one or two 16-bit SDRAM host-port accesses
module mips_sdram_bridge import mips_sdram_bridge_pkg::*; #(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic clk,
  input logic rst,
  mips_sdram_bridge_cpu_if.slave cpu,
  mips_sdram_bridge_mem_if.master mem
);
  state_t state, next;
  logic [ADDR_W-2:0] addr_q;
  logic [31:0] wdata_q, rdata_q;
  logic [3:0] be_q;
  logic is_wr, err_q, req, hi, active, expire, timed_out;
  assign req = cpu.rd || cpu.wr;
  assign hi = state == HI_REQ;
  assign active = state == LO_REQ || state == HI_REQ;
  assign timed_out = active && expire && !mem.done;
  mips_sdram_bridge_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
    .clk(clk), .rst(rst), .clr(next != state), .en(active), .expire(expire)
  );
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = !req ? IDLE : !cpu.wr ? LO_REQ : cpu.be == 4'b0 ? DONE
                    : cpu.be[1:0] != 2'b0 ? LO_REQ : HI_REQ;
      LO_REQ:  next = mem.done ? ((is_wr && be_q[3:2] == 2'b0) ? DONE : HI_GAP)
                    : expire ? DONE : LO_REQ;
      HI_GAP:  next = HI_REQ;
      HI_REQ:  next = (mem.done || expire) ? DONE : HI_REQ;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end
  // A completing access wins over a simultaneous watchdog expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q <= '0;
      is_wr <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && req) begin
        addr_q <= cpu.addr[ADDR_W:2];
        wdata_q <= cpu.wdata;
        be_q <= cpu.be;
        is_wr <= cpu.wr;
        err_q <= 1'b0;
      end
      if (active && !is_wr && mem.valid)
        rdata_q <= hi ? {mem.rdata, rdata_q[15:0]} : {rdata_q[31:16], mem.rdata};
      if (timed_out) begin
        err_q <= 1'b1;
        rdata_q <= '0;
      end
    end
  end
  assign cpu.stall = (state == IDLE && req) || active || state == HI_GAP;
  assign cpu.ack = state == DONE;
  assign cpu.err = state == DONE && err_q;
  assign cpu.rdata = rdata_q;
  assign mem.addr = {addr_q, hi};
  assign mem.data = pick_half(wdata_q, hi);
  assign mem.dm = is_wr ? ~pick_be(be_q, hi) : 2'b00;
  assign mem.rd = active && !is_wr;
  assign mem.wr = active && is_wr;
endmodule

// File: tb/tb_mips_sdram_bridge.sv
// tb_mips_sdram_bridge: directed scoreboard bench with a latency-programmable SDRAM host-port model
module tb_mips_sdram_bridge;
  import mips_sdram_bridge_pkg::*;
  localparam int AW = 22;
  typedef struct {logic [AW-1:0] addr; logic [15:0] data; logic [1:0] dm;} wr_t;
  typedef struct {logic err; logic [31:0] rdata; bit is_rd;} rsp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  int lat = 0;
  bit hang = 1'b0;
  int wait_n = 0;
  int obs_i = 0;
  wr_t exp_wr[$];
  wr_t obs_wr[$];
  rsp_t exp_rsp[$];
  logic [15:0] mem_arr [logic [AW-1:0]];
  logic [15:0] cur;
  mips_sdram_bridge_cpu_if cif();
  mips_sdram_bridge_mem_if #(.ADDR_W(AW)) mif();
  mips_sdram_bridge #(.TIMEOUT_CYC(8), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .cpu(cif), .mem(mif));
  always #5 clk = ~clk;
  // Memory model: completes a request after lat extra cycles, never when hang is set.
  always @(negedge clk) begin
    mif.done = 1'b0;
    mif.valid = 1'b0;
    if ((mif.rd || mif.wr) && !hang && wait_n >= lat) begin
      wait_n = 0;
      mif.done = 1'b1;
      if (mif.rd) begin
        mif.valid = 1'b1;
        mif.rdata = mem_arr.exists(mif.addr) ? mem_arr[mif.addr] : 16'h0000;
      end else begin
        obs_wr.push_back('{mif.addr, mif.data, mif.dm});
        cur = mem_arr.exists(mif.addr) ? mem_arr[mif.addr] : 16'h0000;
        for (int b = 0; b < 2; b++)
          if (!mif.dm[b]) cur[8*b +: 8] = mif.data[8*b +: 8];
        mem_arr[mif.addr] = cur;
      end
    end else wait_n = (mif.rd || mif.wr) ? wait_n + 1 : 0;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic ew(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] m);
    exp_wr.push_back('{a, d, m});
  endtask
  task automatic er(input logic e, input logic [31:0] d, input bit r);
    exp_rsp.push_back('{e, d, r});
  endtask
  task automatic access(input string tag, input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be, input bit hold,
                        output int waits, output int req_cyc);
    rsp_t e;
    @(negedge clk);
    cif.wr = w; cif.rd = r; cif.addr = a; cif.wdata = wd; cif.be = be;
    waits = 0;
    req_cyc = 0;
    do begin
      @(negedge clk);
      waits++;
      if (mif.rd || mif.wr) req_cyc++;
    end while (!cif.ack && waits < 100);
    chk({tag, "_ack"}, 64'(cif.ack), 64'd1);
    e = exp_rsp.pop_front();
    chk({tag, "_err"}, 64'(cif.err), 64'(e.err));
    if (e.is_rd) chk({tag, "_rdata"}, 64'(cif.rdata), 64'(e.rdata));
    if (!hold) begin
      cif.wr = 1'b0;
      cif.rd = 1'b0;
    end
  endtask
  task automatic check_writes(input string tag);
    wr_t e;
    chk({tag, "_nwr"}, 64'(obs_wr.size() - obs_i), 64'(exp_wr.size()));
    while (exp_wr.size() > 0 && obs_i < obs_wr.size()) begin
      e = exp_wr.pop_front();
      chk({tag, "_wr"}, 64'({obs_wr[obs_i].addr, obs_wr[obs_i].data, obs_wr[obs_i].dm}),
          64'({e.addr, e.data, e.dm}));
      obs_i++;
    end
    exp_wr.delete();
  endtask
  initial begin
    int w, q, i;
    cif.rd = 1'b0; cif.wr = 1'b0; cif.addr = '0; cif.wdata = '0; cif.be = '0;
    repeat (3) @(negedge clk);
    chk("rst_cpu", 64'({cif.stall, cif.ack, cif.err, cif.rdata}), 64'd0);
    chk("rst_mem", 64'({mif.rd, mif.wr, mif.addr, mif.data, mif.dm}), 64'd0);
    rst = 1'b0;
    ew(22'h80, 16'h1234, 2'b00); ew(22'h81, 16'hA5A5, 2'b00); er(1'b0, '0, 1'b0);
    access("st_full", 1'b1, 1'b0, 32'h100, 32'hA5A5_1234, 4'hF, 1'b0, w, q);
    chk("st_full_waits", 64'(w), 64'd4);
    check_writes("st_full");
    ew(22'h101, 16'hBEEF, 2'b00); er(1'b0, '0, 1'b0);
    access("st_hi", 1'b1, 1'b0, 32'h200, 32'hBEEF_CAFE, 4'b1100, 1'b0, w, q);
    chk("st_hi_waits", 64'(w), 64'd2);
    check_writes("st_hi");
    ew(22'h100, 16'h2233, 2'b01); er(1'b0, '0, 1'b0);
    access("st_b1", 1'b1, 1'b0, 32'h200, 32'h1111_2233, 4'b0010, 1'b0, w, q);
    chk("st_b1_waits", 64'(w), 64'd2);
    check_writes("st_b1");
    er(1'b0, 32'hA5A5_1234, 1'b1);
    access("ld", 1'b0, 1'b1, 32'h100, '0, 4'h0, 1'b0, w, q);
    chk("ld_lat", 64'(w), 64'd4);
    @(negedge clk);
    chk("ld_hold", 64'(cif.rdata), 64'hA5A5_1234);
    lat = 2;
    er(1'b0, 32'hA5A5_1234, 1'b1);
    access("ld_slow", 1'b0, 1'b1, 32'h100, '0, 4'h0, 1'b0, w, q);
    chk("ld_slow_lat", 64'(w), 64'd8);
    hang = 1'b1;
    er(1'b1, 32'h0, 1'b1);
    access("tmo", 1'b0, 1'b1, 32'h300, '0, 4'h0, 1'b0, w, q);
    chk("tmo_rdcyc", 64'(q), 64'd8);
    chk("tmo_waits", 64'(w), 64'd9);
    hang = 1'b0;
    check_writes("tmo");
    lat = 1;
    ew(22'h200, 16'hF00D, 2'b00); ew(22'h201, 16'h0BAD, 2'b00); er(1'b0, '0, 1'b0);
    access("rdwr", 1'b1, 1'b1, 32'h400, 32'h0BAD_F00D, 4'hF, 1'b0, w, q);
    check_writes("rdwr");
    er(1'b0, 32'h0BAD_F00D, 1'b1);
    access("rdwr_rb", 1'b0, 1'b1, 32'h400, '0, 4'h0, 1'b0, w, q);
    lat = 3;
    ew(22'h280, 16'h6666, 2'b00);
    @(negedge clk);
    cif.wr = 1'b1; cif.addr = 32'h500; cif.wdata = 32'h5555_6666; cif.be = 4'hF;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!(mif.wr && mif.addr[0]) && i < 100);
    chk("rst_mid_hi", 64'(mif.wr && mif.addr[0]), 64'd1);
    rst = 1'b1;
    cif.wr = 1'b0;
    @(negedge clk);
    chk("rst_mid_cpu", 64'({cif.stall, cif.ack, cif.err, cif.rdata}), 64'd0);
    chk("rst_mid_mem", 64'({mif.rd, mif.wr, mif.addr, mif.data, mif.dm}), 64'd0);
    chk("rst_mid_state", 64'(dut.state), 64'(IDLE));
    rst = 1'b0;
    check_writes("rst_mid");
    lat = 0;
    er(1'b0, '0, 1'b0);
    access("be0", 1'b1, 1'b0, 32'h600, 32'hFFFF_FFFF, 4'b0000, 1'b0, w, q);
    chk("be0_waits", 64'(w), 64'd1);
    chk("be0_reqcyc", 64'(q), 64'd0);
    check_writes("be0");
    er(1'b0, 32'h0BAD_F00D, 1'b1);
    access("b2b_a", 1'b0, 1'b1, 32'h400, '0, 4'h0, 1'b1, w, q);
    chk("b2b_a_lat", 64'(w), 64'd4);
    er(1'b0, 32'h0BAD_F00D, 1'b1);
    access("b2b_b", 1'b0, 1'b1, 32'h400, '0, 4'h0, 1'b0, w, q);
    chk("b2b_gap", 64'(w), 64'd4);
    ew(22'h3FFFFE, 16'h5678, 2'b00); ew(22'h3FFFFF, 16'h9ABC, 2'b10); er(1'b0, '0, 1'b0);
    access("wrap", 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h9ABC_5678, 4'b0111, 1'b0, w, q);
    check_writes("wrap");
    ew(22'h4, 16'h00EF, 2'b10); er(1'b0, '0, 1'b0);
    access("st_lo", 1'b1, 1'b0, 32'h8, 32'h0000_00EF, 4'b0001, 1'b0, w, q);
    chk("st_lo_waits", 64'(w), 64'd2);
    check_writes("st_lo");
    er(1'b0, 32'h00BC_5678, 1'b1);
    access("ld_wrap", 1'b0, 1'b1, 32'h007F_FFFC, '0, 4'h0, 1'b0, w, q);
    chk("rsp_drained", 64'(exp_rsp.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
